// File: rtl/ntt_pkg.sv
// Shared encodings for the NTT core: FSM states, twiddle width, butterfly modes.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int TW_W = 12;

    localparam logic MODE_CT = 1'b0;
    localparam logic MODE_GS = 1'b1;

    // Stage twiddle base: (1<<lm) + ((core<<lm)>>log_core_count)
    function automatic logic [31:0] tw_base(
        input int         core,
        input int         lcc,
        input logic [3:0] lm
    );
        return (32'd1 << lm) + ((32'(core) << lm) >> lcc);
    endfunction

endpackage

// File: rtl/ntt_core_param_if.sv
// Bank write port and butterfly result stream of the NTT core.
interface ntt_core_param_if #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 30
);
    logic [LANES-1:0]          wr_en;
    logic [LANES*ADDR_W-1:0]   wr_addr;
    logic [LANES*2*DATA_W-1:0] wr_data;
    logic                      out_valid;
    logic [ADDR_W-1:0]         out_addr;
    logic [LANES*2*DATA_W-1:0] out_data;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  out_valid, out_addr, out_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output out_valid, out_addr, out_data
    );
endinterface

// File: rtl/ntt_butterfly_unit.sv
// Modular CT/GS butterfly; BF_LAT register stages, first stage captures the twiddle.
module ntt_butterfly_unit
    import ntt_pkg::*;
#(
    parameter int          DATA_W = 30,
    parameter int unsigned Q      = 1073479681,
    parameter int          BF_LAT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [DATA_W-1:0]   w,
    output logic [2*DATA_W-1:0] res
);
    localparam int              PW = 2 * DATA_W;
    localparam int              W1 = DATA_W + 1;
    localparam logic [DATA_W:0] QS = W1'(Q);
    localparam logic [PW-1:0]   QP = PW'(Q);

    function automatic logic [DATA_W-1:0] add_q(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] y
    );
        logic [DATA_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QS) s = s - QS;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] sub_q(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] y
    );
        logic [DATA_W:0] d;
        if (x >= y) d = {1'b0, x} - {1'b0, y};
        else        d = {1'b0, x} + QS - {1'b0, y};
        return d[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] mul_x;
    logic [DATA_W-1:0] prod_q;
    logic [DATA_W-1:0] sum_y;
    logic [DATA_W-1:0] res_a;
    logic [DATA_W-1:0] res_b;

    // GS multiplies the difference, CT multiplies b before the add/sub
    always_comb begin
        d_in   = sub_q(a, b);
        mul_x  = (mode == MODE_GS) ? d_in : b;
        prod_q = DATA_W'(({{DATA_W{1'b0}}, mul_x}
                 * {{DATA_W{1'b0}}, w}) % QP);
        sum_y  = (mode == MODE_GS) ? b : prod_q;
        res_a  = add_q(a, sum_y);
        res_b  = (mode == MODE_GS) ? prod_q : sub_q(a, prod_q);
    end

    logic [PW-1:0] pipe [BF_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BF_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {res_b, res_a};
            for (int i = 1; i < BF_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign res = pipe[BF_LAT-1];
endmodule

// File: rtl/ntt_core_param.sv
// NTT pass engine: ping-pong pair banks per lane feeding LANES butterflies.
module ntt_core_param
    import ntt_pkg::*;
#(
    parameter int          DATA_W         = 30,
    parameter int unsigned Q              = 1073479681,
    parameter int          LANES          = 2,
    parameter int          ADDR_W         = 9,
    parameter int          CORE_INDEX     = 0,
    parameter int          LOG_CORE_COUNT = 5,
    parameter int          BF_LAT         = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    inverse,
    input  logic [3:0]              log_m,
    input  logic [ADDR_W:0]         num_reads,
    output logic [LANES*TW_W-1:0]   tw_addr,
    input  logic [LANES*DATA_W-1:0] tw_data,
    output logic                    busy,
    output logic                    done,
    ntt_core_param_if.slave         bus
);
    localparam int              PW    = 2 * DATA_W;
    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE_N = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W:0]     num_q;
    logic                mode_q;
    logic                rd_sel;
    logic [3:0]          lm_q;
    logic [BF_LAT:0]     vld;
    logic [ADDR_W-1:0]   vaddr [BF_LAT+1];
    logic                rd_fire;
    logic                rd_last;
    logic [31:0]         base;
    logic [LANES*PW-1:0] res_all;

    assign rd_fire = (state == ST_READ);
    assign rd_last = rd_fire && ({1'b0, rd_addr} == num_q - ONE_N);
    assign base    = tw_base(CORE_INDEX, LOG_CORE_COUNT, lm_q);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nx = (num_reads == '0) ? ST_DONE : ST_READ;
            end
            ST_READ:  if (rd_last) state_nx = ST_DRAIN;
            ST_DRAIN: if (vld == '0) state_nx = ST_DONE;
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr <= '0;
            num_q   <= '0;
            mode_q  <= MODE_CT;
            lm_q    <= '0;
            rd_sel  <= 1'b0;
            vld     <= '0;
        end else begin
            vld <= {vld[BF_LAT-1:0], rd_fire};
            if (state == ST_IDLE && start) begin
                rd_addr <= '0;
                num_q   <= num_reads;
                mode_q  <= inverse;
                lm_q    <= log_m;
            end else if (rd_fire) begin
                rd_addr <= rd_addr + ONE_A;
            end
            if (state == ST_DONE) rd_sel <= ~rd_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= BF_LAT; i++) vaddr[i] <= '0;
        end else begin
            vaddr[0] <= rd_addr;
            for (int i = 1; i <= BF_LAT; i++) vaddr[i] <= vaddr[i-1];
        end
    end

    assign bus.out_valid = vld[BF_LAT];
    assign bus.out_addr  = vaddr[BF_LAT];
    assign bus.out_data  = res_all;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [PW-1:0]     mem [2][DEPTH];
        logic [PW-1:0]     ram_q;
        logic [ADDR_W-1:0] wa;

        assign wa = bus.wr_addr[l*ADDR_W +: ADDR_W];

        // Writer fills the bank the current pass is not reading
        always_ff @(posedge clk) begin
            if (bus.wr_en[l]) mem[~rd_sel][wa] <= bus.wr_data[l*PW +: PW];
            ram_q <= mem[rd_sel][rd_addr];
        end

        assign tw_addr[l*TW_W +: TW_W] =
            TW_W'(base + 32'(rd_addr) * 32'(LANES) + 32'(l));

        ntt_butterfly_unit #(
            .DATA_W (DATA_W),
            .Q      (Q),
            .BF_LAT (BF_LAT)
        ) u_bf (
            .clk  (clk),
            .rst  (rst),
            .mode (mode_q),
            .a    (ram_q[DATA_W-1:0]),
            .b    (ram_q[PW-1:DATA_W]),
            .w    (tw_data[l*DATA_W +: DATA_W]),
            .res  (res_all[l*PW +: PW])
        );
    end
endmodule

// File: tb/tb_ntt_core_param.sv
// Scoreboard bench for ntt_core_param with a Q=17 two-lane configuration.
module tb_ntt_core_param;
    localparam int          DATA_W         = 5;
    localparam int unsigned Q              = 17;
    localparam int          LANES          = 2;
    localparam int          ADDR_W         = 4;
    localparam int          CORE_INDEX     = 3;
    localparam int          LOG_CORE_COUNT = 5;
    localparam int          BF_LAT         = 4;
    localparam int          PW             = 2 * DATA_W;

    logic                    clk       = 1'b0;
    logic                    rst       = 1'b1;
    logic                    start     = 1'b0;
    logic                    inverse   = 1'b0;
    logic [3:0]              log_m     = '0;
    logic [ADDR_W:0]         num_reads = '0;
    logic [LANES*12-1:0]     tw_addr;
    logic [LANES*DATA_W-1:0] tw_data   = '0;
    logic                    busy;
    logic                    done;

    ntt_core_param_if #(
        .LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) bus ();

    ntt_core_param #(
        .DATA_W(DATA_W), .Q(Q), .LANES(LANES), .ADDR_W(ADDR_W),
        .CORE_INDEX(CORE_INDEX), .LOG_CORE_COUNT(LOG_CORE_COUNT),
        .BF_LAT(BF_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse),
        .log_m(log_m), .num_reads(num_reads), .tw_addr(tw_addr),
        .tw_data(tw_data), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // Twiddle ROM: w = index mod Q, one cycle after the index
    always @(posedge clk)
        for (int l = 0; l < LANES; l++)
            tw_data[l*DATA_W +: DATA_W] <=
                DATA_W'(int'(tw_addr[l*12 +: 12]) % Q);

    typedef struct {
        logic [ADDR_W-1:0]   addr;
        logic [LANES*PW-1:0] data;
    } exp_t;

    exp_t                sb[$];
    exp_t                got_e;
    logic [PW-1:0]       shadow [LANES][2][1<<ADDR_W];
    bit                  tb_sel;
    int                  n_vec;
    int                  n_err;
    int                  dones;
    int                  valids;
    logic [LANES*PW-1:0] first_data;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] bfly(input bit inv, input int a,
                                           input int b, input int w);
        int qa, qb, qi;
        qi = int'(Q);
        if (!inv) begin
            qa = (a + w * b) % qi;
            qb = ((a - w * b) % qi + qi) % qi;
        end else begin
            qa = (a + b) % qi;
            qb = ((((a - b) % qi + qi) % qi) * w) % qi;
        end
        return {DATA_W'(qb), DATA_W'(qa)};
    endfunction

    function automatic int tw_idx(input int lm, input int r, input int l);
        return ((1 << lm) + ((CORE_INDEX << lm) >> LOG_CORE_COUNT)
                + r * LANES + l) & 'hFFF;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                got_e = sb.pop_front();
                check("out_addr", bus.out_addr, got_e.addr);
                check("out_data", bus.out_data, got_e.data);
            end
        end
    end

    task automatic write_bank(input int n, input bit fixed);
        for (int r = 0; r < n; r++) begin
            @(negedge clk);
            for (int l = 0; l < LANES; l++) begin
                logic [PW-1:0] p;
                p = {DATA_W'($urandom_range(0, Q - 1)),
                     DATA_W'($urandom_range(0, Q - 1))};
                if (fixed && r == 0 && l == 0)
                    p = {DATA_W'(5), DATA_W'(3)};
                bus.wr_data[l*PW +: PW]         = p;
                bus.wr_addr[l*ADDR_W +: ADDR_W] = ADDR_W'(r);
                shadow[l][~tb_sel][r]           = p;
            end
            bus.wr_en = '1;
        end
        @(negedge clk);
        bus.wr_en = '0;
    endtask

    task automatic run_pass(input bit inv, input int lm, input int n,
                            input bit hold);
        int cyc, first, last, cnt;
        bit got_done;
        for (int r = 0; r < n; r++) begin
            exp_t x;
            x.addr = ADDR_W'(r);
            x.data = '0;
            for (int l = 0; l < LANES; l++) begin
                logic [PW-1:0] p;
                p = shadow[l][tb_sel][r];
                x.data[l*PW +: PW] = bfly(inv, int'(p[DATA_W-1:0]),
                    int'(p[PW-1:DATA_W]), tw_idx(lm, r, l) % int'(Q));
            end
            sb.push_back(x);
        end
        @(negedge clk);
        start     = 1'b1;
        inverse   = inv;
        log_m     = 4'(lm);
        num_reads = (ADDR_W + 1)'(n);
        @(negedge clk);
        if (!hold) start = 1'b0;
        inverse   = ~inv;
        log_m     = 4'(lm + 1);
        num_reads = '1;
        cyc = 1; first = -1; last = -1; cnt = 0; got_done = 0;
        check("busy_in_pass", busy, 1);
        while (!got_done && cyc < 100) begin
            if (cyc <= n)
                for (int l = 0; l < LANES; l++)
                    check("tw_addr", tw_addr[l*12 +: 12],
                          tw_idx(lm, cyc - 1, l));
            if (bus.out_valid) begin
                if (first < 0) begin
                    first      = cyc;
                    first_data = bus.out_data;
                end
                last = cyc;
                cnt++;
            end
            if (done) got_done = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", got_done, 1);
        if (n == 0) check("done_latency", cyc, 1);
        else begin
            check("first_out_latency", first, 2 + BF_LAT);
            check("out_valid_contig", last - first + 1, n);
        end
        check("out_valid_count", cnt, n);
        tb_sel = ~tb_sel;
        @(negedge clk);
        check("idle_after_done", {busy, done}, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        bus.wr_en   = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        tb_sel = 0;
        n_vec  = 0;
        n_err  = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_out_data", bus.out_data, 0);
        rst = 1'b0;

        write_bank(8, 1);
        run_pass(0, 6, 0, 0);
        write_bank(8, 1);
        run_pass(0, 6, 1, 1);
        check("fwd_example", first_data[PW-1:0],
              {DATA_W'(10), DATA_W'(13)});
        run_pass(1, 6, 1, 0);
        check("inv_example", first_data[PW-1:0],
              {DATA_W'(13), DATA_W'(8)});
        run_pass(0, 6, 4, 0);

        fork
            run_pass(1, 3, 8, 0);
            begin
                @(negedge clk);
                write_bank(8, 0);
            end
        join
        run_pass(0, 2, 8, 0);

        @(negedge clk);
        start = 1'b1; num_reads = 8; inverse = 1'b0; log_m = 4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        dones  = 0;
        valids = 0;
        repeat (20) begin
            @(negedge clk);
            dones  += int'(done);
            valids += int'(bus.out_valid);
        end
        check("abort_no_done", dones, 0);
        check("abort_no_valid", valids, 0);
        tb_sel = 0;
        run_pass(0, 1, 3, 0);

        check("sb_empty_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
